// File: rtl/linear_proj_pkg.sv
// Shared types and sizing for the linear projection datapath and its BRAM loader.
// Loader widths are derived from the multiplier array geometry and matrix sizes.
package linear_proj_pkg;

  localparam int unsigned WIDTH_A     = 16;
  localparam int unsigned CHUNK_SIZE  = 4;
  localparam int unsigned NUM_CORES_A = 4;

  localparam int unsigned MAT_A_ROWS = 32;
  localparam int unsigned MAT_A_COLS = 32;
  localparam int unsigned MAT_B_ROWS = 32;
  localparam int unsigned MAT_B_COLS = 32;

  // One beat carries a full row slice for every core.
  localparam int unsigned ELEMS_PER_BEAT = CHUNK_SIZE * NUM_CORES_A;
  localparam int unsigned LOADER_DATA_W  = WIDTH_A * ELEMS_PER_BEAT;

  localparam int unsigned WORDS_A = (MAT_A_ROWS * MAT_A_COLS) / ELEMS_PER_BEAT;
  localparam int unsigned WORDS_B = (MAT_B_ROWS * MAT_B_COLS) / ELEMS_PER_BEAT;
  localparam int unsigned LOADER_DEPTH = (WORDS_A > WORDS_B) ? WORDS_A : WORDS_B;

  typedef enum logic [1:0] {
    StIdle,
    StEven,
    StOdd,
    StFin
  } loader_state_t;

endpackage

// File: rtl/bram_pair_packer.sv
// Holds the even beat and registers the dual-port (or odd-tail port-A-only) BRAM write.
// Strobes are high for exactly one cycle after the completing beat is accepted.
module bram_pair_packer
  import linear_proj_pkg::*;
#(
  parameter int unsigned DATA_W = LOADER_DATA_W,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CH_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   ch,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              even_fire,
  input  logic              even_last,
  input  logic              odd_fire,
  input  logic [DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0] bram_ena,
  output logic [NUM_CH-1:0] bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic [NUM_CH-1:0] bram_enb,
  output logic [NUM_CH-1:0] bram_web,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dinb
);

  logic [DATA_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] en_a_q, en_a_d, en_b_q, en_b_d;
  logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic [DATA_W-1:0] dina_q, dina_d, dinb_q, dinb_d;
  logic [NUM_CH-1:0] ch_oh;

  assign ch_oh = NUM_CH'(1) << ch;

  always_comb begin
    hold_d  = hold_q;
    en_a_d  = '0;
    en_b_d  = '0;
    addra_d = addra_q;
    addrb_d = addrb_q;
    dina_d  = dina_q;
    dinb_d  = dinb_q;
    if (even_fire) begin
      hold_d = s_data;
    end
    if (even_fire && even_last) begin
      // Odd-length tail: the even beat goes straight out on port A alone.
      en_a_d  = ch_oh;
      addra_d = base_addr;
      dina_d  = s_data;
    end else if (odd_fire) begin
      en_a_d  = ch_oh;
      en_b_d  = ch_oh;
      addra_d = base_addr;
      addrb_d = base_addr | ADDR_W'(1);
      dina_d  = hold_q;
      dinb_d  = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      en_a_q  <= '0;
      en_b_q  <= '0;
      addra_q <= '0;
      addrb_q <= '0;
      dina_q  <= '0;
      dinb_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
      dina_q  <= dina_d;
      dinb_q  <= dinb_d;
    end
  end

  assign bram_ena   = en_a_q;
  assign bram_wea   = en_a_q;
  assign bram_enb   = en_b_q;
  assign bram_web   = en_b_q;
  assign bram_addra = addra_q;
  assign bram_addrb = addrb_q;
  assign bram_dina  = dina_q;
  assign bram_dinb  = dinb_q;

endmodule

// File: rtl/bram_pair_loader.sv
// Streams beats into per-channel dual-port BRAMs as even/odd pairs and tracks load completion.
// Optional LOADER_STATUS_EN adds err_len and beat_cnt status outputs.
module bram_pair_loader
  import linear_proj_pkg::*;
#(
  parameter int unsigned DATA_W = LOADER_DATA_W,
  parameter int unsigned DEPTH  = LOADER_DEPTH,
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0] bram_ena,
  output logic [NUM_CH-1:0] bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic [NUM_CH-1:0] bram_enb,
  output logic [NUM_CH-1:0] bram_web,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dinb,
  output logic              load_done,
  output logic [NUM_CH-1:0] loaded_mask,
  output logic              compute_start,
`ifdef LOADER_STATUS_EN
  output logic              err_len,
  output logic [ADDR_W:0]   beat_cnt,
`endif
  input  logic              compute_done
);

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              started_q;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   base_ext;
  logic              even_last, odd_last;
  logic              even_fire, odd_fire;
  logic              all_loaded;

  assign len_clamped = (cfg_len > DepthLen) ? DepthLen : cfg_len;
  assign base_ext    = {1'b0, base_q};
  assign even_last   = (base_ext + (ADDR_W + 1)'(1)) == len_q;
  assign odd_last    = (base_ext + (ADDR_W + 1)'(2)) == len_q;
  assign even_fire   = (state_q == StEven) && s_valid;
  assign odd_fire    = (state_q == StOdd) && s_valid;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    len_d     = len_q;
    base_d    = base_q;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          ch_d    = cfg_ch;
          len_d   = len_clamped;
          base_d  = '0;
          state_d = (len_clamped == '0) ? StFin : StEven;
        end
      end
      StEven: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_d = even_last ? StFin : StOdd;
        end
      end
      StOdd: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // Wrap to 0 only happens on the final pair, which exits to StFin.
          base_d  = base_q + ADDR_W'(2);
          state_d = odd_last ? StFin : StEven;
        end
      end
      StFin: begin
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A completing load wins over a same-cycle compute_done clear.
  always_comb begin
    mask_d = mask_q;
    if (compute_done) begin
      mask_d = '0;
    end
    if (state_q == StFin) begin
      mask_d = mask_d | (NUM_CH'(1) << ch_q);
    end
  end

  assign all_loaded    = &mask_q;
  assign compute_start = all_loaded && !started_q;
  assign loaded_mask   = mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      len_q     <= '0;
      base_q    <= '0;
      mask_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      len_q     <= len_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
      started_q <= all_loaded;
    end
  end

`ifdef LOADER_STATUS_EN
  logic            err_len_q;
  logic [ADDR_W:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_len_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        beat_cnt_q <= '0;
        if (cfg_len > DepthLen) begin
          err_len_q <= 1'b1;
        end
      end else if (s_valid && s_ready) begin
        beat_cnt_q <= beat_cnt_q + (ADDR_W + 1)'(1);
      end
    end
  end

  assign err_len  = err_len_q;
  assign beat_cnt = beat_cnt_q;
`endif

  bram_pair_packer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .ch         (ch_q),
    .base_addr  (base_q),
    .even_fire  (even_fire),
    .even_last  (even_last),
    .odd_fire   (odd_fire),
    .s_data     (s_data),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_enb   (bram_enb),
    .bram_web   (bram_web),
    .bram_addrb (bram_addrb),
    .bram_dinb  (bram_dinb)
  );

endmodule
